// File: rtl/button_debounce_repeat.sv
// Turns one raw active-low key into a debounced level plus fixed-width press/auto-repeat pulses.
// Latency: DEBOUNCE_CYCLES+1 edges to btn_level, press pulse one edge later; no backpressure (free-running).
module button_debounce_repeat #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int PULSE_CYCLES    = 4,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n,
    input  logic repeat_en,
    output logic btn_level,
    output logic pulse_out,
    output logic repeating
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [PW-1:0]    PW_LOAD  = PW'(PULSE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_WAIT = 2'd1,
        ST_REPEAT     = 2'd2
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             btn_level_q, btn_level_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
    logic             fire;

    // Two-stage synchronizer on the inverted (active-high) key.
    always_comb begin
        sync1_d = ~button_n;
        sync2_d = sync1_q;
    end

    // Any sample matching the stable level restarts the debounce window.
    always_comb begin
        db_cnt_d    = db_cnt_q;
        btn_level_d = btn_level_q;
        if (sync2_q == btn_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_level_d = sync2_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_level_q) begin
                    fire      = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = ST_PRESS_WAIT;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_level_q) begin
                    state_d = ST_IDLE;
                end else if (!repeat_en) begin
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == RD_LAST) begin
                    fire      = 1'b1;
                    rpt_cnt_d = '0;
                    state_d   = ST_REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (!btn_level_q) begin
                    state_d = ST_IDLE;
                end else if (!repeat_en) begin
                    rpt_cnt_d = '0;
                    state_d   = ST_PRESS_WAIT;
                end else if (rpt_cnt_q == RP_LAST) begin
                    fire      = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    // Stretcher runs independently of the FSM so a release never truncates a pulse.
    always_comb begin
        pulse_cnt_d = pulse_cnt_q;
        if (fire) begin
            pulse_cnt_d = PW_LOAD;
        end else if (pulse_cnt_q != '0) begin
            pulse_cnt_d = pulse_cnt_q - PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            btn_level_q <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            rpt_cnt_q   <= '0;
            pulse_cnt_q <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            btn_level_q <= btn_level_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign btn_level = btn_level_q;
    assign pulse_out = (pulse_cnt_q != '0);
    assign repeating = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_button_debounce_repeat.sv
// Bench for button_debounce_repeat: table of press scenarios plus hand-written release/bounce/reset sequences.
module tb_button_debounce_repeat;

    localparam int D  = 8;
    localparam int RD = 20;
    localparam int RP = 10;
    localparam int PC = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic button_n;
    logic repeat_en;
    logic btn_level;
    logic pulse_out;
    logic repeating;

    button_debounce_repeat #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .PULSE_CYCLES   (PC),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .button_n (button_n),
        .repeat_en(repeat_en),
        .btn_level(btn_level),
        .pulse_out(pulse_out),
        .repeating(repeating)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = -1;
    int exp_q[$];
    int n_pulses = 0;
    int rpt_cyc  = 0;
    int lvl_cyc  = 0;
    int start_edge = 0;
    bit pulse_prev = 1'b0;
    bit chk_width  = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: counts edges, pops expected pulse start edges, checks pulse widths.
    always @(posedge clk) begin
        edge_n = edge_n + 1;
        #1;
        if (pulse_out && !pulse_prev) begin
            start_edge = edge_n;
            n_pulses++;
            if (exp_q.size() == 0) check("unexpected_pulse_edge", edge_n, -1);
            else check("pulse_start_edge", edge_n, exp_q.pop_front());
        end
        if (!pulse_out && pulse_prev && chk_width)
            check("pulse_width", edge_n - start_edge, PC);
        if (repeating) rpt_cyc++;
        if (btn_level) lvl_cyc++;
        pulse_prev = pulse_out;
    end

    // Drives one press; called and returns at a negedge. Value set at step i is sampled at edge s+i.
    task automatic run_press(input int hold, input int en_at, input int tail);
        for (int i = 0; i < hold + tail; i++) begin
            button_n  = (i < hold) ? 1'b0 : 1'b1;
            repeat_en = (i >= en_at);
            @(negedge clk);
        end
    endtask

    typedef struct {
        int hold;
        int en_at;
        int np;
        int p0, p1, p2, p3, p4;
        int rpt;
        int lvl;
    } row_t;

    localparam int NROWS = 6;
    row_t tbl[NROWS];

    initial begin
        int s, f, np0;
        int ps[5];

        // Edges relative to first pressed sample; pulse starts (-1 unused), repeating cycles, btn_level cycles.
        tbl[0] = '{20,   0,    1, 10, -1, -1, -1, -1,  0, 20};
        tbl[1] = '{60,   0,    5, 10, 30, 40, 50, 60, 40, 60};
        tbl[2] = '{60,   1000, 1, 10, -1, -1, -1, -1,  0, 60};
        tbl[3] = '{85,   61,   3, 10, 80, 90, -1, -1, 15, 85};
        tbl[4] = '{8,    0,    1, 10, -1, -1, -1, -1,  0,  8};
        tbl[5] = '{7,    0,    0, -1, -1, -1, -1, -1,  0,  0};

        reset_n   = 1'b1;
        button_n  = 1'b1;
        repeat_en = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("reset_btn_level", btn_level, 0);
        check("reset_pulse_out", pulse_out, 0);
        check("reset_repeating", repeating, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < NROWS; r++) begin
            s  = edge_n + 1;
            ps = '{tbl[r].p0, tbl[r].p1, tbl[r].p2, tbl[r].p3, tbl[r].p4};
            for (int k = 0; k < 5; k++)
                if (ps[k] >= 0) exp_q.push_back(s + ps[k]);
            rpt_cyc = 0;
            lvl_cyc = 0;
            np0 = n_pulses;
            run_press(tbl[r].hold, tbl[r].en_at, 40);
            check($sformatf("row%0d_missing_pulses", r), exp_q.size(), 0);
            check($sformatf("row%0d_pulse_count", r), n_pulses - np0, tbl[r].np);
            check($sformatf("row%0d_repeating_cycles", r), rpt_cyc, tbl[r].rpt);
            check($sformatf("row%0d_level_cycles", r), lvl_cyc, tbl[r].lvl);
            exp_q.delete();
        end

        // Bounce: toggles every 3 cycles for 40 cycles, then released.
        lvl_cyc = 0;
        np0 = n_pulses;
        for (int i = 0; i < 70; i++) begin
            button_n = (i < 40 && ((i / 3) % 2 == 0)) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        check("bounce_level_cycles", lvl_cyc, 0);
        check("bounce_pulse_count", n_pulses - np0, 0);

        // Release debounces during the first repeat pulse: pulse stays full width, FSM already IDLE.
        s = edge_n + 1;
        exp_q.push_back(s + 10);
        exp_q.push_back(s + 30);
        np0 = n_pulses;
        fork
            run_press(22, 0, 40);
            begin
                repeat (33) @(posedge clk);
                #2;
                check("rel_pulse_out_mid", pulse_out, 1);
                check("rel_repeating_idle", repeating, 0);
                check("rel_btn_level_low", btn_level, 0);
            end
        join
        check("rel_missing_pulses", exp_q.size(), 0);
        check("rel_pulse_count", n_pulses - np0, 2);
        exp_q.delete();

        // Reset while in REPEAT with a pulse active, key still held afterwards.
        s = edge_n + 1;
        exp_q.push_back(s + 10);
        exp_q.push_back(s + 30);
        button_n  = 1'b0;
        repeat_en = 1'b1;
        repeat (33) @(posedge clk);
        #3;
        check("pre_rst_repeating", repeating, 1);
        check("pre_rst_pulse_out", pulse_out, 1);
        check("pre_rst_btn_level", btn_level, 1);
        chk_width = 1'b0;
        reset_n = 1'b0;
        #1;
        check("rst_btn_level", btn_level, 0);
        check("rst_pulse_out", pulse_out, 0);
        check("rst_repeating", repeating, 0);
        check("rst_pending_pulses", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk_width = 1'b1;
        f = edge_n + 1;
        exp_q.push_back(f + 10);
        lvl_cyc = 0;
        rpt_cyc = 0;
        np0 = n_pulses;
        for (int i = 0; i < 45; i++) begin
            button_n = (i < 15) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        check("post_rst_missing_pulse", exp_q.size(), 0);
        check("post_rst_pulse_count", n_pulses - np0, 1);
        check("post_rst_level_cycles", lvl_cyc, 15);
        check("post_rst_repeating_cycles", rpt_cyc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_chk);
        $fatal(1);
    end

endmodule
